// File: rtl/tristate_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter_pkg
//   Shared definitions for the tri-state bus arbiter:
//     - state_e      : arbiter FSM state encoding (IDLE, OWN, TURN)
//     - DEF_NREQ     : default number of requesters (4)
//     - DEF_MAX_HOLD : default maximum consecutive ownership cycles (8)
//     - OWNER_W      : width of an owner index
//     - HOLD_W       : width of the hold counter (covers MAX_HOLD up to 15)
// -----------------------------------------------------------------------------
package tristate_bus_arbiter_pkg;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int OWNER_W      = 2;
    localparam int HOLD_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // bus free, nobody requesting
        OWN  = 2'd1,   // one requester drives the bus
        TURN = 2'd2    // one dead cycle between owners, bus released
    } state_e;

endpackage

// File: rtl/tristate_bus_arbiter_lane_driver.sv
// -----------------------------------------------------------------------------
// bus_lane_driver
//   One requester's tri-state driver onto the shared bus. Drives its data
//   while enabled, otherwise releases every bit to Z.
//   Ports:
//     en_i   : drive enable (the requester's registered grant bit)
//     data_i : requester data, N bits
//     bus_o  : connection to the shared tri-state bus, N bits
// -----------------------------------------------------------------------------
module bus_lane_driver #(
    parameter int N = 4
) (
    input  logic         en_i,
    input  logic [N-1:0] data_i,
    output tri   [N-1:0] bus_o
);

    assign bus_o = en_i ? data_i : {N{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//   Round-robin arbiter for a shared tri-state bus with four requesters.
//   An owner keeps the bus while it requests, up to MAX_HOLD cycles, then a
//   single TURN cycle with every driver released separates it from the next
//   owner so two drivers never overlap.
//   Ports:
//     clk       : clock, all state changes on the rising edge
//     rst       : synchronous active-high reset
//     req       : per-requester level-sensitive bus request [NREQ]
//     data_in   : packed requester data, slice i = bits [i*N +: N]
//     grant     : registered one-hot grant, zero when nobody owns the bus
//     owner     : index of the current owner, meaningful while bus_valid=1
//     bus_valid : registered, high while a granted requester drives the bus
//     bus       : shared tri-state bus, data_in[owner] or all Z
// -----------------------------------------------------------------------------
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   data_in,
    output logic [NREQ-1:0]     grant,
    output logic [OWNER_W-1:0]  owner,
    output logic                bus_valid,
    output tri   [N-1:0]        bus
);

    state_e               state_q;
    logic [NREQ-1:0]      grant_q;
    logic [OWNER_W-1:0]   owner_q;
    logic                 bus_valid_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [OWNER_W-1:0]   last_owner_q;

    logic                 win_valid;
    logic [OWNER_W-1:0]   win_idx;
    logic [OWNER_W-1:0]   cand;

    // Round-robin selector. Scanning from the farthest offset down to the
    // nearest lets the nearest active requester after last_owner_q win;
    // offset NREQ wraps back to last_owner_q itself, so the previous owner
    // is considered last. Index arithmetic wraps naturally in OWNER_W bits.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_owner_q + OWNER_W'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbiter FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            bus_valid_q  <= 1'b0;
            hold_q       <= '0;
            last_owner_q <= OWNER_W'(NREQ - 1);
        end else begin
            case (state_q)
                // IDLE and TURN both hand the bus to the round-robin winner
                // if anyone is requesting; TURN otherwise falls back to IDLE.
                IDLE, TURN: begin
                    if (win_valid) begin
                        state_q     <= OWN;
                        grant_q     <= NREQ'(1) << win_idx;
                        owner_q     <= win_idx;
                        bus_valid_q <= 1'b1;
                        hold_q      <= '0;
                    end else begin
                        state_q     <= IDLE;
                    end
                end

                // hold_q counts completed ownership cycles minus one, so
                // leaving at MAX_HOLD-1 gives at most MAX_HOLD grant cycles.
                OWN: begin
                    if (!req[owner_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
                        state_q      <= TURN;
                        grant_q      <= '0;
                        bus_valid_q  <= 1'b0;
                        hold_q       <= '0;
                        last_owner_q <= owner_q;
                    end else begin
                        hold_q       <= hold_q + 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    grant_q     <= '0;
                    bus_valid_q <= 1'b0;
                    hold_q      <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign bus_valid = bus_valid_q;

    // One driver per requester; only the lane whose grant bit is set drives.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        bus_lane_driver #(
            .N (N)
        ) u_lane (
            .en_i   (grant_q[i]),
            .data_i (data_in[i*N +: N]),
            .bus_o  (bus)
        );
    end

endmodule
